multi_hit_priority_encoder: RTL and testbench

MULTI_HIT_PRIORITY_ENCODER -- requirements
Module: multi_hit_priority_encoder

---
 rtl/mhpe_pkg.sv | 15 +
 rtl/chunk_prio_find.sv | 30 +++
 rtl/multi_hit_priority_encoder.sv | 134 +++++++++++++
 tb/tb_multi_hit_priority_encoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mhpe_pkg.sv
// Shared types and constants for the multi-hit priority encoder.
// Holds the controller state encoding and the priority-order mode values.
package mhpe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } mhpe_state_e;

    localparam logic MODE_MSB_FIRST = 1'b0;
    localparam logic MODE_LSB_FIRST = 1'b1;

endpackage

// File: rtl/chunk_prio_find.sv
// Combinational finder: reports whether a chunk has any set bit and the local
// index of the highest-priority one for the given mode.
module chunk_prio_find
    import mhpe_pkg::*;
#(
    parameter int CHUNK_LEN = 8,
    parameter int IDX_W     = (CHUNK_LEN > 1) ? $clog2(CHUNK_LEN) : 1
) (
    input  logic [CHUNK_LEN-1:0] chunk_i,
    input  logic                 mode_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     idx_o
);

    // The last assignment in each loop wins, so loop direction sets priority.
    always_comb begin
        found_o = |chunk_i;
        idx_o   = '0;
        if (mode_i == MODE_LSB_FIRST) begin
            for (int i = CHUNK_LEN - 1; i >= 0; i--) begin
                if (chunk_i[i]) idx_o = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < CHUNK_LEN; i++) begin
                if (chunk_i[i]) idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/multi_hit_priority_encoder.sv
// Emits the index of every set bit of a captured vector, one handshake per hit,
// in strict priority order, scanning one chunk per cycle.
module multi_hit_priority_encoder
    import mhpe_pkg::*;
#(
    parameter  int DATA_LEN   = 32,
    parameter  int CHUNK_LEN  = 8,
    localparam int RESULT_LEN = $clog2(DATA_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    input  logic                  mode,
    input  logic [DATA_LEN-1:0]   data_in,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [RESULT_LEN-1:0] result,
    output logic                  result_last,
    output logic                  done,
    output logic                  zero_f,
    output logic [RESULT_LEN:0]   hit_count
);

    localparam int NCHUNK = DATA_LEN / CHUNK_LEN;
    localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LIDX_W = (CHUNK_LEN > 1) ? $clog2(CHUNK_LEN) : 1;

    mhpe_state_e          state_q, state_d;
    logic [DATA_LEN-1:0]  w_q, w_d;
    logic                 mode_q, mode_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [RESULT_LEN:0]  hit_count_q, hit_count_d;
    logic                 zero_f_q, zero_f_d;

    logic [PTR_W-1:0]      cidx;
    logic [CHUNK_LEN-1:0]  chunk;
    logic                  found;
    logic [LIDX_W-1:0]     lidx;
    logic [RESULT_LEN-1:0] abs_idx;
    logic                  one_left;
    logic                  ptr_last;

    // ptr counts scan steps; cidx maps it onto a physical chunk for the mode.
    always_comb begin
        cidx     = (mode_q == MODE_MSB_FIRST) ? (PTR_W'(NCHUNK - 1) - ptr_q) : ptr_q;
        chunk    = CHUNK_LEN'(w_q >> (int'(cidx) * CHUNK_LEN));
        abs_idx  = RESULT_LEN'(int'(cidx) * CHUNK_LEN + int'(lidx));
        one_left = (w_q != '0) && ((w_q & (w_q - DATA_LEN'(1))) == '0);
        ptr_last = (ptr_q == PTR_W'(NCHUNK - 1));
    end

    chunk_prio_find #(
        .CHUNK_LEN (CHUNK_LEN),
        .IDX_W     (LIDX_W)
    ) u_find (
        .chunk_i (chunk),
        .mode_i  (mode_q),
        .found_o (found),
        .idx_o   (lidx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            mode_q      <= MODE_MSB_FIRST;
            ptr_q       <= '0;
            hit_count_q <= '0;
            zero_f_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            mode_q      <= mode_d;
            ptr_q       <= ptr_d;
            hit_count_q <= hit_count_d;
            zero_f_q    <= zero_f_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        mode_d      = mode_q;
        ptr_d       = ptr_q;
        hit_count_d = hit_count_q;
        zero_f_d    = zero_f_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d         = data_in;
                    mode_d      = mode;
                    ptr_d       = '0;
                    hit_count_d = '0;
                    zero_f_d    = 1'b0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (found) begin
                    state_d = ST_EMIT;
                end else if (ptr_last) begin
                    zero_f_d = (hit_count_q == '0);
                    state_d  = ST_DONE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            ST_EMIT: begin
                // The pointer stays put so the same chunk is rescanned for further hits.
                if (result_ready) begin
                    w_d         = w_q & ~(DATA_LEN'(1) << abs_idx);
                    hit_count_d = hit_count_q + (RESULT_LEN + 1)'(1);
                    state_d     = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready        = (state_q == ST_IDLE);
        result_valid = (state_q == ST_EMIT);
        result       = (state_q == ST_EMIT) ? abs_idx : '0;
        result_last  = (state_q == ST_EMIT) && one_left;
        done         = (state_q == ST_DONE);
        zero_f       = zero_f_q;
        hit_count    = hit_count_q;
    end

endmodule

// File: tb/tb_multi_hit_priority_encoder.sv
// Directed bench for multi_hit_priority_encoder at DATA_LEN=32, CHUNK_LEN=8.
module tb_multi_hit_priority_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic        mode;
    logic [31:0] data_in;
    logic        result_valid;
    logic        result_ready;
    logic [4:0]  result;
    logic        result_last;
    logic        done;
    logic        zero_f;
    logic [5:0]  hit_count;

    int checks = 0;
    int errors = 0;

    int res_q[$];
    int last_q[$];
    int done_cyc;
    int zf_at_done;
    int hc_at_done;

    always #5 clk = ~clk;

    multi_hit_priority_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ready        (ready),
        .mode         (mode),
        .data_in      (data_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_last  (result_last),
        .done         (done),
        .zero_f       (zero_f),
        .hit_count    (hit_count)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one operation; stall = cycles result_ready is held low per hit.
    task automatic run_op(input logic [31:0] d, input logic m, input int stall,
                          input bit inject);
        int cyc;
        int scnt;
        int held_res;
        int held_last;
        res_q.delete();
        last_q.delete();
        done_cyc = -1;
        scnt = 0;
        held_res = 0;
        held_last = 0;
        result_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; data_in = d; mode = m;
        @(negedge clk);
        start = 1'b0;
        if (inject) begin
            start = 1'b1; data_in = 32'hFFFF_FFFF; mode = ~m;
        end
        cyc = 1;
        chk("busy_after_start", ready, 0);
        while (cyc < 300) begin
            if (cyc == 3) begin
                start = 1'b0; data_in = 32'h0; mode = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                zf_at_done = zero_f;
                hc_at_done = hit_count;
                break;
            end
            if (result_valid) begin
                if (scnt == 0) begin
                    held_res = result;
                    held_last = result_last;
                end else begin
                    chk("stall_result", result, held_res);
                    chk("stall_last", result_last, held_last);
                end
                if (scnt < stall) begin
                    result_ready = 1'b0;
                    scnt++;
                end else begin
                    result_ready = 1'b1;
                    res_q.push_back(result);
                    last_q.push_back(result_last);
                    scnt = 0;
                end
            end else if (result != 5'd0) begin
                chk("result_zero_idle", result, 0);
            end
            @(negedge clk);
            cyc++;
        end
        result_ready = 1'b1;
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("ready_after_done", ready, 1);
        chk("done_one_cycle", done, 0);
        chk("zf_hold", zero_f, zf_at_done);
        chk("hc_hold", hit_count, hc_at_done);
    endtask

    task automatic expect_hits(input string tag, input int exp_res[], input int exp_last[],
                               input int exp_done, input int exp_zf);
        chk({tag, "_nhits"}, res_q.size(), exp_res.size());
        for (int i = 0; i < exp_res.size() && i < res_q.size(); i++) begin
            chk({tag, "_res"}, res_q[i], exp_res[i]);
            chk({tag, "_last"}, last_q[i], exp_last[i]);
        end
        chk({tag, "_done_cyc"}, done_cyc, exp_done);
        chk({tag, "_zero_f"}, zf_at_done, exp_zf);
        chk({tag, "_hit_count"}, hc_at_done, exp_res.size());
    endtask

    initial begin
        int wait_cyc;
        rst = 1'b0; start = 1'b0; mode = 1'b0; data_in = 32'h0; result_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_last", result_last, 0);
        chk("rst_done", done, 0);
        chk("rst_zero_f", zero_f, 0);
        chk("rst_hit_count", hit_count, 0);
        rst = 1'b1;

        // All-zero: done in cycle 5, ready in 6
        run_op(32'h0000_0000, 1'b0, 0, 1'b0);
        expect_hits("zero", '{}, '{}, 5, 1);

        // Each hit adds one EMIT and one SCAN cycle, plus stalls
        run_op(32'h8000_0001, 1'b0, 0, 1'b0);
        expect_hits("msb2", '{31, 0}, '{0, 1}, 9, 0);

        run_op(32'h8000_0001, 1'b1, 0, 1'b0);
        expect_hits("lsb2", '{0, 31}, '{0, 1}, 9, 0);

        run_op(32'h0000_00F0, 1'b0, 3, 1'b0);
        expect_hits("stall", '{7, 6, 5, 4}, '{0, 0, 0, 1}, 25, 0);

        run_op(32'h0000_0300, 1'b1, 0, 1'b0);
        expect_hits("lsbchunk", '{8, 9}, '{0, 1}, 9, 0);

        run_op(32'h0000_0100, 1'b0, 0, 1'b1);
        expect_hits("inject", '{8}, '{1}, 7, 0);

        // Reset while a hit is being presented
        @(negedge clk);
        result_ready = 1'b0;
        start = 1'b1; data_in = 32'h00FF_0000; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (!result_valid && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("rstemit_valid_seen", result_valid, 1);
        chk("rstemit_result", result, 23);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        result_ready = 1'b1;
        chk("rstemit_valid", result_valid, 0);
        chk("rstemit_ready", ready, 1);
        chk("rstemit_done", done, 0);
        chk("rstemit_hit_count", hit_count, 0);
        chk("rstemit_result0", result, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || result_valid) chk("rstemit_quiet", 1, 0);
        end
        chk("rstemit_idle", ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
